// File: rtl/pluck_envelope.sv
// Plucked-string amplitude envelope (linear attack, decay to silence) that PWM-gates a square-wave tone.
// Optional macro PLUCK_EXP_DECAY_EN selects approximately exponential decay instead of linear.
module pluck_envelope #(
  parameter int ATTACK_DIV = 50000,
  parameter int ATTACK_INC = 16,
  parameter int DECAY_DIV  = 390625,
  parameter int PWM_BITS   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wave_in,
  input  logic [2:0]          note,
  input  logic                strike,
  output logic                audio_out,
  output logic [PWM_BITS-1:0] level,
  output logic                active
);

  localparam int MAX_DIV = (ATTACK_DIV > DECAY_DIV) ? ATTACK_DIV : DECAY_DIV;
  localparam int PS_W    = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;
  localparam logic [PS_W-1:0]   A_LAST = PS_W'(ATTACK_DIV - 1);
  localparam logic [PS_W-1:0]   D_LAST = PS_W'(DECAY_DIV - 1);
  localparam logic [PWM_BITS:0] FULL   = {1'b0, {PWM_BITS{1'b1}}};

  typedef enum logic [1:0] {IDLE = 2'd0, ATTACK = 2'd1, DECAY = 2'd2} state_t;

  state_t              state, state_n;
  logic [PS_W-1:0]     presc, presc_n;
  logic [PWM_BITS-1:0] level_n, dec, pwm_cnt;
  logic [PWM_BITS:0]   sum;
  logic                wave_s1, wave_s2;

  // Next decay level; both forms floor at 0 so reaching 0 is the IDLE condition.
  always_comb begin
    dec = '0;
`ifdef PLUCK_EXP_DECAY_EN
    if (level > ((level >> 4) + PWM_BITS'(1)))
      dec = level - ((level >> 4) + PWM_BITS'(1));
`else
    if (level != '0)
      dec = level - PWM_BITS'(1);
`endif
  end

  always_comb begin
    state_n = state;
    level_n = level;
    presc_n = presc + 1'b1;
    sum     = {1'b0, level} + (PWM_BITS+1)'(ATTACK_INC);
    case (state)
      IDLE: begin
        presc_n = '0;
        level_n = '0;
      end
      ATTACK: begin
        if (presc == A_LAST) begin
          presc_n = '0;
          if (sum >= FULL) begin
            level_n = '1;
            state_n = DECAY;
          end else begin
            level_n = sum[PWM_BITS-1:0];
          end
        end
      end
      DECAY: begin
        if (presc == D_LAST) begin
          presc_n = '0;
          level_n = dec;
          if (dec == '0) state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        presc_n = '0;
        level_n = '0;
      end
    endcase
    // Strike overrides any coincident tick; level is kept so a retrigger does not click.
    if (strike) begin
      state_n = ATTACK;
      presc_n = '0;
      level_n = (state == IDLE) ? '0 : level;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      presc  <= '0;
      level  <= '0;
      active <= 1'b0;
    end else begin
      state  <= state_n;
      presc  <= presc_n;
      level  <= level_n;
      active <= (state_n != IDLE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wave_s1   <= 1'b0;
      wave_s2   <= 1'b0;
      pwm_cnt   <= '0;
      audio_out <= 1'b0;
    end else begin
      wave_s1   <= wave_in;
      wave_s2   <= wave_s1;
      pwm_cnt   <= pwm_cnt + 1'b1;
      audio_out <= wave_s2 & (pwm_cnt < level) & (note != 3'd7);
    end
  end

endmodule
